// File: rtl/instr_fetch.sv
// Instruction fetch stage: byte-addressed PC, bench-loadable instruction memory
// and a 2-entry valid/ready queue feeding instr_decode, with redirect and flush.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          id_ready,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   ir,
  output logic                          ir_valid,
  output logic [31:0]                   ir_pc,
  output logic                          fetch_fault
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  // One bit wider than the PC so the limit itself is representable for any depth.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic [31:0] mem [IMEM_DEPTH];
  entry_t      q [2];
  logic [1:0]  count;
  logic [31:0] pc;
  logic        fault;

  logic        in_range;
  logic        redirect_ok;
  logic        pop;
  logic        push;
  entry_t      new_entry;

  // NOTE: the instruction memory has no reset; it is a RAM whose contents
  // survive reset, so clearing it would be wrong and would block RAM inference.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_comb begin
    in_range        = {1'b0, pc} < PC_LIMIT;
    redirect_ok     = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < PC_LIMIT);
    ir_valid        = count != 2'd0;
    pop             = ir_valid & id_ready;
    push            = !fault & !redirect & in_range & ((count != 2'd2) | pop);
    new_entry.instr = mem[pc[AW+1:2]];
    new_entry.pc    = pc;
    ir              = ir_valid ? q[0].instr : 32'h0;
    ir_pc           = ir_valid ? q[0].pc : 32'h0;
    fetch_fault     = fault;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of count, pc and the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      fault <= 1'b0;
      q[0]  <= '0;
      q[1]  <= '0;
    end else if (redirect) begin
      count <= 2'd0;
      if (redirect_ok) begin
        pc    <= redirect_pc;
        fault <= 1'b0;
      end else begin
        fault <= 1'b1;
      end
    end else begin
      if (!in_range) fault <= 1'b1;
      if (push) pc <= pc + 32'd4;
      // Head always lives in q[0]; a pop shifts q[1] down.
      unique case ({push, pop})
        2'b10: begin
          q[count[0]] <= new_entry;
          count       <= count + 2'd1;
        end
        2'b01: begin
          q[0]  <= q[1];
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q[0] <= new_entry;
          end else begin
            q[0] <= q[1];
            q[1] <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
